// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler.
// Build option: define UART_PARITY_EN to insert an odd parity bit between d7 and stop.
package uart_pkg;

`ifdef UART_PARITY_EN
  localparam int unsigned FRAME_W = 11;
`else
  localparam int unsigned FRAME_W = 10;
`endif

  // Bit positions within a frame, in transmission order
  localparam int unsigned BIT_START   = 0;
  localparam int unsigned BIT_DATA_LO = 1;
  localparam int unsigned BIT_DATA_HI = 8;
  localparam int unsigned BIT_PARITY  = 9;
  localparam int unsigned BIT_STOP    = FRAME_W - 1;

  typedef enum logic [1:0] {IDLE, ARM, SHIFT} state_e;

  // 1 when the byte holds an even number of ones, making data+parity odd
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  // Full serial frame, bit 0 goes out first
  function automatic logic [FRAME_W-1:0] build_frame(input logic [7:0] d);
    logic [FRAME_W-1:0] f;
    f = '1;
    f[BIT_START] = 1'b0;
    f[BIT_DATA_HI:BIT_DATA_LO] = d;
`ifdef UART_PARITY_EN
    f[BIT_PARITY] = odd_parity(d);
`endif
    f[BIT_STOP] = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer, with wrap.
module uart_rr_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [2:0]       i_ptr,
  output logic [N_REQ-1:0] o_onehot,
  output logic [2:0]       o_idx,
  output logic             o_valid
);

  logic [2*N_REQ-1:0] w_req2;

  assign w_req2 = {i_req, i_req};

  // Scanning the doubled vector from the pointer position covers the wrap without modular indexing
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    for (int unsigned i = 0; i < 2 * N_REQ; i++) begin
      if (!o_valid && (i >= 32'(i_ptr)) && w_req2[i]) begin
        o_valid                = 1'b1;
        o_idx                  = 3'(i % N_REQ);
        o_onehot[i % N_REQ]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART TX line among N_REQ byte requesters with round-robin arbitration.
// Build option: UART_PARITY_EN selects an 11-bit frame with odd parity (10-bit otherwise).
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    uart_tick,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        grant,
  output logic [2:0]              grant_id,
  output logic                    busy,
  output logic                    tx
);

  localparam logic [3:0] LAST_BIT = 4'(FRAME_W - 1);

  state_e             r_state;
  logic [2:0]         r_ptr;
  logic [N_REQ-1:0]   r_grant;
  logic [2:0]         r_grant_id;
  logic               r_busy;
  logic               r_tx;
  logic [3:0]         r_bitcnt;
  logic [FRAME_W-1:0] r_frame;

  logic [N_REQ-1:0]   w_onehot;
  logic [2:0]         w_idx;
  logic               w_valid;
  logic [7:0]         w_byte;
  logic [2:0]         w_ptr_next;

  uart_rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_valid  (w_valid)
  );

  // Select the winning requester's byte
  always_comb begin
    w_byte = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_onehot[i]) w_byte = req_data[DATA_W*i +: 8];
    end
  end

  assign w_ptr_next = (w_idx == 3'(N_REQ - 1)) ? 3'd0 : w_idx + 3'd1;

  // Arbitrate in IDLE, wait for tick alignment in ARM, shift one frame bit per tick in SHIFT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_busy     <= 1'b0;
      r_tx       <= 1'b1;
      r_bitcnt   <= '0;
      r_frame    <= '1;
    end else begin
      r_grant <= '0;
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_grant    <= w_onehot;
            r_grant_id <= w_idx;
            r_busy     <= 1'b1;
            r_frame    <= build_frame(w_byte);
            r_ptr      <= w_ptr_next;
            r_state    <= ARM;
          end
        end
        ARM: begin
          if (uart_tick) begin
            r_tx     <= r_frame[0];
            r_frame  <= {1'b1, r_frame[FRAME_W-1:1]};
            r_bitcnt <= '0;
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (uart_tick) begin
            if (r_bitcnt == LAST_BIT) begin
              // tx already holds the stop level, so the line stays idle-high
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_bitcnt <= r_bitcnt + 4'd1;
              r_tx     <= r_frame[0];
              r_frame  <= {1'b1, r_frame[FRAME_W-1:1]};
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant    = r_grant;
  assign grant_id = r_grant_id;
  assign busy     = r_busy;
  assign tx       = r_tx;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: table of arbitration vectors plus
// hand sequences for round-robin, idle-after-reset and mid-frame reset.
module tb_uart_tx_scheduler;

  localparam int NR       = 4;
  localparam int TICK_DIV = 8;
`ifdef UART_PARITY_EN
  localparam int          FW        = 11;
  localparam logic [10:0] A5_FRAME  = 11'b1_1_10100101_0;
  localparam logic [10:0] F07_FRAME = 11'b1_0_00000111_0;
`else
  localparam int          FW        = 10;
  localparam logic [10:0] A5_FRAME  = 11'b0_1_10100101_0;
  localparam logic [10:0] F07_FRAME = 11'b0_1_00000111_0;
`endif

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic              uart_tick = 1'b0;
  logic [NR-1:0]     req       = '0;
  logic [NR*8-1:0]   req_data  = '0;
  logic [NR-1:0]     grant;
  logic [2:0]        grant_id;
  logic              busy;
  logic              tx;

  int n_vec = 0;
  int n_err = 0;

  uart_tx_scheduler #(
    .N_REQ  (NR),
    .DATA_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_tick (uart_tick),
    .req       (req),
    .req_data  (req_data),
    .grant     (grant),
    .grant_id  (grant_id),
    .busy      (busy),
    .tx        (tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_to(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Reference frame, independent of the RTL: count ones for parity
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    int ones;
    logic par;
    ones = 0;
    for (int i = 0; i < 8; i++) if (b[i]) ones++;
    par = (ones % 2 == 0);
`ifdef UART_PARITY_EN
    return {1'b1, par, b, 1'b0};
`else
    return {1'b0, 1'b1, b, 1'b0};
`endif
  endfunction

  // Scoreboard and monitor state
  logic [7:0]  exp_q[$];
  int          gnt_log[$];
  int          tick_cnt  = 0;
  int          frames    = 0;
  int          n_push    = 0;
  logic [10:0] last_frame = '0;
  logic [10:0] m_sh      = '1;
  int          m_cnt     = 0;
  bit          m_in      = 1'b0;
  logic        prev_busy = 1'b0;
  int          div       = 0;

  // Monitor first (reacting to the tick the DUT just saw), then advance the tick generator
  always @(negedge clk) begin
    if (!rst_n) begin
      m_in      = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (grant !== '0) begin
        chk("grant_onehot", 32'($onehot(grant)), 32'd1);
        chk("grant_only_from_idle", 32'(prev_busy), 32'd0);
        gnt_log.push_back(int'(grant_id));
      end
      if (uart_tick) begin
        tick_cnt++;
        if (!m_in) begin
          if (tx === 1'b0) begin
            m_in  = 1'b1;
            m_sh  = {1'b0, 10'h3FF};
            m_cnt = 1;
          end
        end else begin
          m_sh = {tx, m_sh[10:1]};
          m_cnt++;
          if (m_cnt == FW) begin
            logic [7:0]  b;
            logic [10:0] rx;
            m_in = 1'b0;
            frames++;
            rx = m_sh >> (11 - FW);
            last_frame = rx;
            if (exp_q.size() == 0) begin
              fail_to("unexpected_frame");
            end else begin
              b = exp_q.pop_front();
              chk("frame_bits", 32'(rx), 32'(model_frame(b)));
            end
          end
        end
      end
      prev_busy = busy;
    end
    div = (div == TICK_DIV - 1) ? 0 : div + 1;
    uart_tick = (div == TICK_DIV - 1);
  end

  task automatic wait_grant(output bit ok, output int t0);
    ok = 1'b0;
    t0 = 0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk); #1;
      if (grant !== '0) begin
        ok = 1'b1;
        t0 = tick_cnt;
      end
    end
    if (!ok) fail_to("grant_timeout");
  endtask

  task automatic wait_idle(output bit ok, output int t1);
    ok = 1'b0;
    t1 = 0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge clk); #1;
      if (busy === 1'b0) begin
        ok = 1'b1;
        t1 = tick_cnt;
      end
    end
    if (!ok) fail_to("busy_fall_timeout");
  endtask

  typedef struct {
    logic [NR-1:0]   req;
    logic [NR*8-1:0] data;
    int              exp_id;
  } vec_t;

  vec_t vt[10];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    int t0, t1, n0, f0;
    logic acc_tx, acc_busy;
    logic [NR-1:0] acc_gnt;
    int rr_exp[5];

    // Pointer after the round-robin sequence is 1; expectations follow from there
    vt[0] = '{4'b0001, 32'h000000A5, 0};
    vt[1] = '{4'b0001, 32'h00000007, 0};
    vt[2] = '{4'b0100, 32'h00C30000, 2};
    vt[3] = '{4'b0101, 32'h0081003C, 0};
    vt[4] = '{4'b0101, 32'h0081003C, 2};
    vt[5] = '{4'b1010, 32'h0000F000, 3};
    vt[6] = '{4'b1010, 32'h0000F000, 1};
    vt[7] = '{4'b1111, 32'h5A6B7C8D, 2};
    vt[8] = '{4'b1001, 32'hE1000012, 3};
    vt[9] = '{4'b0010, 32'h0000FF00, 1};
    rr_exp = '{0, 1, 2, 3, 0};

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_grant_id", 32'(grant_id), 32'd0);

    // Idle with no requests for 20 ticks
    rst_n = 1'b1;
    t0 = tick_cnt;
    acc_tx = 1'b1; acc_busy = 1'b0; acc_gnt = '0;
    for (int c = 0; c < 40 * TICK_DIV && (tick_cnt - t0) < 20; c++) begin
      @(negedge clk); #1;
      acc_tx   = acc_tx & tx;
      acc_busy = acc_busy | busy;
      acc_gnt  = acc_gnt | grant;
    end
    chk("idle_tick_count", 32'(tick_cnt - t0), 32'd20);
    chk("idle_tx_high", 32'(acc_tx), 32'd1);
    chk("idle_busy_low", 32'(acc_busy), 32'd0);
    chk("idle_no_grant", 32'(acc_gnt), 32'd0);

    // Round-robin with all four requesters held high
    req_data = 32'h44332211;
    foreach (rr_exp[g]) begin
      exp_q.push_back(8'(req_data >> (8 * rr_exp[g])));
      n_push++;
    end
    n0 = gnt_log.size();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_grant(ok, t0);
      if (!ok) break;
    end
    req = '0;
    wait_idle(ok, t1);
    chk("rr_grant_count", 32'(gnt_log.size() - n0), 32'd5);
    for (int g = 0; g < 5; g++) begin
      if (n0 + g < gnt_log.size())
        chk("rr_grant_order", 32'(gnt_log[n0 + g]), 32'(rr_exp[g]));
    end

    // Table-driven single transfers: arbitration from a moving pointer, frame timing
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      req_data = vt[k].data;
      req      = vt[k].req;
      exp_q.push_back(8'(vt[k].data >> (8 * vt[k].exp_id)));
      n_push++;
      f0 = frames;
      wait_grant(ok, t0);
      if (ok) begin
        chk("vec_grant_onehot", 32'(grant), 32'd1 << vt[k].exp_id);
        chk("vec_grant_id", 32'(grant_id), 32'(vt[k].exp_id));
        chk("vec_busy_at_grant", 32'(busy), 32'd1);
        req = '0;
        @(negedge clk); #1;
        chk("vec_grant_pulse_width", 32'(grant), 32'd0);
        wait_idle(ok, t1);
        if (ok) begin
          chk("vec_tick_span", 32'(t1 - t0), 32'(FW + 1));
          chk("vec_tx_idle_after", 32'(tx), 32'd1);
          chk("vec_frame_received", 32'(frames - f0), 32'd1);
          if (k == 0) chk("frame_A5_const", 32'(last_frame), 32'(A5_FRAME));
          if (k == 1) chk("frame_07_const", 32'(last_frame), 32'(F07_FRAME));
        end
      end else begin
        req = '0;
      end
    end

    // Reset during d3 of 0xFF aborts the frame; a fresh grant follows release
    @(negedge clk); #1;
    req_data = 32'h000000FF;
    req      = 4'b0001;
    n0 = gnt_log.size();
    wait_grant(ok, t0);
    for (int c = 0; c < 100 * TICK_DIV && (tick_cnt - t0) < 5; c++) begin
      @(negedge clk); #1;
    end
    chk("midframe_busy_before_reset", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midframe_reset_tx", 32'(tx), 32'd1);
    chk("midframe_reset_busy", 32'(busy), 32'd0);
    chk("midframe_reset_grant", 32'(grant), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("midframe_held_grant", 32'(grant), 32'd0);
    exp_q.push_back(8'hFF);
    n_push++;
    rst_n = 1'b1;
    wait_grant(ok, t0);
    if (ok) begin
      chk("post_reset_grant", 32'(grant), 32'd1);
      chk("post_reset_grant_id", 32'(grant_id), 32'd0);
    end
    req = '0;
    wait_idle(ok, t1);
    if (ok) chk("post_reset_tick_span", 32'(t1 - t0), 32'(FW + 1));
    chk("midframe_grant_count", 32'(gnt_log.size() - n0), 32'd2);

    repeat (4) @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("frames_total", 32'(frames), 32'(n_push));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
